// File: rtl/inference_test_sequencer.sv
// Sweeps stored test vectors through an inference engine, compares each result with its label
// and keeps saturating correct/wrong/timeout tallies; no backpressure, a per-test handshake via dut_start/dut_ready.
module inference_test_sequencer #(
  parameter int NUM_TESTS    = 750,
  parameter int NUM_FEATURES = 62,
  parameter int DATA_W       = 8,
  parameter int LABEL_W      = 4,
  parameter int START_LEN    = 2,
  parameter int SETTLE       = 2,
  parameter int TIMEOUT      = 4096,
  localparam int IW = (NUM_TESTS > 2) ? $clog2(NUM_TESTS) : 1,
  localparam int CW = $clog2(NUM_TESTS + 1),
  localparam int VW = NUM_FEATURES * DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               abort,
  input  logic               stop_on_err,
  output logic [IW-1:0]      test_addr,
  input  logic [VW-1:0]      test_vec,
  input  logic [LABEL_W-1:0] test_label,
  output logic [VW-1:0]      dut_input,
  output logic               dut_start,
  input  logic [LABEL_W-1:0] dut_result,
  input  logic               dut_ready,
  output logic               busy,
  output logic               done,
  output logic               err_stop,
  output logic [CW-1:0]      correct_cnt,
  output logic [CW-1:0]      wrong_cnt,
  output logic [CW-1:0]      timeout_cnt,
  output logic               mis_valid,
  output logic [IW-1:0]      mis_index,
  output logic [LABEL_W-1:0] mis_result,
  output logic [LABEL_W-1:0] mis_label
);

  localparam int PMAX = (START_LEN > SETTLE) ? START_LEN : SETTLE;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX + 1) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  state_t               state;
  logic [IW-1:0]        index;
  logic [LABEL_W-1:0]   label_q;
  logic [PW-1:0]        phase;
  logic [TW-1:0]        wait_cnt;
  logic                 tmo;
  logic                 stop_latch;
  logic                 result_bad;

  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign result_bad = (dut_result != label_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      index       <= '0;
      test_addr   <= '0;
      dut_input   <= '0;
      dut_start   <= 1'b0;
      label_q     <= '0;
      phase       <= '0;
      wait_cnt    <= '0;
      tmo         <= 1'b0;
      stop_latch  <= 1'b0;
      err_stop    <= 1'b0;
      correct_cnt <= '0;
      wrong_cnt   <= '0;
      timeout_cnt <= '0;
      mis_valid   <= 1'b0;
      mis_index   <= '0;
      mis_result  <= '0;
      mis_label   <= '0;
    end else begin
      mis_valid <= 1'b0;
      // Abort only cuts a sweep short; tallies and the last mismatch stay visible.
      if (abort && busy) begin
        state     <= S_IDLE;
        dut_start <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (run && !abort) begin
              correct_cnt <= '0;
              wrong_cnt   <= '0;
              timeout_cnt <= '0;
              err_stop    <= 1'b0;
              index       <= '0;
              test_addr   <= '0;
              stop_latch  <= stop_on_err;
              state       <= S_FETCH;
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            dut_input <= test_vec;
            label_q   <= test_label;
            dut_start <= 1'b1;
            phase     <= PW'(START_LEN - 1);
            state     <= S_START;
          end
          S_START: begin
            if (phase == '0) begin
              dut_start <= 1'b0;
              wait_cnt  <= '0;
              state     <= S_WAIT;
            end else begin
              phase <= phase - 1'b1;
            end
          end
          S_WAIT: begin
            // Ready is tested first so it beats a timeout expiring in the same cycle.
            if (dut_ready) begin
              tmo <= 1'b0;
              if (SETTLE == 0) begin
                state <= S_CHECK;
              end else begin
                phase <= PW'(SETTLE - 1);
                state <= S_SETTLE;
              end
            end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
              tmo <= 1'b1;
              if (timeout_cnt != CW'(NUM_TESTS)) timeout_cnt <= timeout_cnt + 1'b1;
              state <= S_CHECK;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_SETTLE: begin
            if (phase == '0) state <= S_CHECK;
            else             phase <= phase - 1'b1;
          end
          S_CHECK: begin
            if (tmo) begin
              mis_valid  <= 1'b1;
              mis_index  <= index;
              mis_result <= '0;
              mis_label  <= label_q;
            end else if (result_bad) begin
              if (wrong_cnt != CW'(NUM_TESTS)) wrong_cnt <= wrong_cnt + 1'b1;
              mis_valid  <= 1'b1;
              mis_index  <= index;
              mis_result <= dut_result;
              mis_label  <= label_q;
            end else begin
              if (correct_cnt != CW'(NUM_TESTS)) correct_cnt <= correct_cnt + 1'b1;
            end
            if (stop_latch && (tmo || result_bad)) begin
              err_stop <= 1'b1;
              state    <= S_DONE;
            end else if (index == IW'(NUM_TESTS - 1)) begin
              state <= S_DONE;
            end else begin
              index     <= index + 1'b1;
              test_addr <= index + 1'b1;
              state     <= S_FETCH;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inference_test_sequencer.sv
// Scoreboarded bench: directed sweeps push expected start pulses, mismatches and end-of-run tallies;
// a negedge monitor pops and compares as the sequencer produces them.
module tb_inference_test_sequencer;

  localparam int NT = 4;
  localparam int NF = 3;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int SL = 2;
  localparam int ST = 2;
  localparam int TO = 16;
  localparam int IW = 2;
  localparam int CW = 3;
  localparam int VW = NF * DW;

  typedef struct packed {
    logic [1:0]    idx;
    logic [LW-1:0] res;
    logic [LW-1:0] lab;
  } mis_t;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [CW-1:0] w;
    logic [CW-1:0] t;
    logic          e;
    logic [31:0]   cyc;
  } end_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          run, abort, stop_on_err;
  logic [IW-1:0] test_addr;
  logic [VW-1:0] test_vec;
  logic [LW-1:0] test_label;
  logic [VW-1:0] dut_input;
  logic          dut_start;
  logic [LW-1:0] dut_result;
  logic          dut_ready;
  logic          busy, done, err_stop;
  logic [CW-1:0] correct_cnt, wrong_cnt, timeout_cnt;
  logic          mis_valid;
  logic [IW-1:0] mis_index;
  logic [LW-1:0] mis_result, mis_label;

  inference_test_sequencer #(
    .NUM_TESTS(NT), .NUM_FEATURES(NF), .DATA_W(DW), .LABEL_W(LW),
    .START_LEN(SL), .SETTLE(ST), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .abort(abort), .stop_on_err(stop_on_err),
    .test_addr(test_addr), .test_vec(test_vec), .test_label(test_label),
    .dut_input(dut_input), .dut_start(dut_start), .dut_result(dut_result),
    .dut_ready(dut_ready), .busy(busy), .done(done), .err_stop(err_stop),
    .correct_cnt(correct_cnt), .wrong_cnt(wrong_cnt), .timeout_cnt(timeout_cnt),
    .mis_valid(mis_valid), .mis_index(mis_index), .mis_result(mis_result),
    .mis_label(mis_label)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Test memory with a one-cycle registered read.
  logic [VW-1:0] mem_vec [NT];
  logic [LW-1:0] mem_lab [NT];
  always @(posedge clk) begin
    test_vec   <= mem_vec[test_addr];
    test_label <= mem_lab[test_addr];
  end

  // Network model: answers after dut_start falls; index carried in element 0.
  int wrong_idx = -1;
  int hang_idx  = -1;
  int late_idx  = -1;
  bit pending   = 1'b0;
  int ridx      = 0;
  int rcnt      = 0;
  always @(negedge clk) begin
    if (dut_start === 1'b1) begin
      pending   = 1'b1;
      ridx      = int'(dut_input[DW-1:0]);
      rcnt      = (ridx == late_idx) ? TO - 1 : 0;
      dut_ready = 1'b0;
    end else if (pending && ridx != hang_idx) begin
      if (rcnt == 0) begin
        dut_ready  = 1'b1;
        dut_result = (ridx == wrong_idx) ? (mem_lab[ridx] ^ 4'h1) : mem_lab[ridx];
        pending    = 1'b0;
      end else begin
        rcnt--;
        dut_ready = 1'b0;
      end
    end else begin
      dut_ready = 1'b0;
    end
  end

  logic [VW-1:0] exp_vec_q [$];
  mis_t          exp_mis_q [$];
  end_t          exp_end_q [$];

  logic          prev_start = 1'b0;
  logic          prev_done  = 1'b0;
  logic          prev_busy  = 1'b0;
  int            s_len      = 0;
  logic [VW-1:0] s_vec      = '0;
  bit            s_stable   = 1'b0;
  int            busy_cyc   = 0;
  bit            saw3       = 1'b0;

  always @(negedge clk) begin
    mis_t m;
    end_t e;
    logic [VW-1:0] ev;
    if (busy === 1'b1) busy_cyc = (prev_busy === 1'b1) ? busy_cyc + 1 : 1;
    if (busy === 1'b1 && test_addr === 2'd3) saw3 = 1'b1;

    if (dut_start === 1'b1) begin
      if (prev_start !== 1'b1) begin
        s_len = 1; s_vec = dut_input; s_stable = 1'b1;
      end else begin
        s_len++;
        if (dut_input !== s_vec) s_stable = 1'b0;
      end
    end else if (prev_start === 1'b1) begin
      if (exp_vec_q.size() == 0) chk("unexpected_start", 1, 0);
      else begin
        ev = exp_vec_q.pop_front();
        chk("start_vec", s_vec, ev);
        chk("start_len", s_len, SL);
        chk("start_stable", s_stable, 1);
      end
    end

    if (mis_valid === 1'b1) begin
      if (exp_mis_q.size() == 0) chk("unexpected_mis", 1, 0);
      else begin
        m = exp_mis_q.pop_front();
        chk("mis_index", mis_index, m.idx);
        chk("mis_result", mis_result, m.res);
        chk("mis_label", mis_label, m.lab);
      end
    end

    if (done === 1'b1 && prev_done !== 1'b1) begin
      if (exp_end_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = exp_end_q.pop_front();
        chk("end_correct", correct_cnt, e.c);
        chk("end_wrong", wrong_cnt, e.w);
        chk("end_timeout", timeout_cnt, e.t);
        chk("end_err_stop", err_stop, e.e);
        chk("end_busy_cycles", busy_cyc, e.cyc);
      end
    end

    prev_start = dut_start;
    prev_done  = done;
    prev_busy  = busy;
  end

  task automatic push_starts(input int n);
    for (int i = 0; i < n; i++) exp_vec_q.push_back(mem_vec[i]);
  endtask

  task automatic push_end(input int c, input int w, input int t, input logic e, input int cyc);
    end_t x;
    x.c = CW'(c); x.w = CW'(w); x.t = CW'(t); x.e = e; x.cyc = 32'(cyc);
    exp_end_q.push_back(x);
  endtask

  task automatic push_mis(input int idx, input logic [LW-1:0] res, input logic [LW-1:0] lab);
    mis_t x;
    x.idx = 2'(idx); x.res = res; x.lab = lab;
    exp_mis_q.push_back(x);
  endtask

  task automatic pulse_run(input logic soe);
    @(negedge clk);
    run = 1'b1; stop_on_err = soe;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(nm, done, 1);
  endtask

  task automatic wait_start_idx1(input string nm);
    int n = 0;
    while (!(dut_start === 1'b1 && test_addr === 2'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, dut_start, 1);
    n = 0;
    while (dut_start === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_start"}, dut_start, 0);
    chk({nm, "_err_stop"}, err_stop, 0);
    chk({nm, "_counts"}, {correct_cnt, wrong_cnt, timeout_cnt}, 0);
    chk({nm, "_mis"}, {mis_valid, mis_index, mis_result, mis_label}, 0);
    chk({nm, "_addr"}, test_addr, 0);
    chk({nm, "_input"}, dut_input, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; run = 1'b0; abort = 1'b0; stop_on_err = 1'b0;
    dut_ready = 1'b0; dut_result = '0;
    for (int i = 0; i < NT; i++) mem_vec[i] = {8'h5A ^ 8'(i), 8'(8'hA0 + i), 8'(i)};
    mem_lab[0] = 4'd3; mem_lab[1] = 4'd7; mem_lab[2] = 4'd10; mem_lab[3] = 4'd5;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // All correct: 4 tests of 2+2+1+2+1 cycles each.
    saw3 = 1'b0;
    push_starts(4); push_end(4, 0, 0, 1'b0, 32);
    pulse_run(1'b0);
    wait_done("done_all_correct");
    chk("fetched_idx3_all_correct", saw3, 1);

    // Wrong answer on index 2, keep going.
    wrong_idx = 2;
    push_starts(4); push_mis(2, 4'd11, 4'd10); push_end(3, 1, 0, 1'b0, 32);
    pulse_run(1'b0);
    wait_done("done_wrong_nostop");

    // Same, halting on the first error.
    saw3 = 1'b0;
    push_starts(3); push_mis(2, 4'd11, 4'd10); push_end(2, 1, 0, 1'b1, 24);
    pulse_run(1'b1);
    wait_done("done_wrong_stop");
    chk("no_fetch_idx3", saw3, 0);
    chk("stop_addr", test_addr, 2);
    wrong_idx = -1;

    // Index 1 never answers: 16 WAIT cycles then CHECK, no settle.
    hang_idx = 1;
    push_starts(4); push_mis(1, 4'd0, 4'd7); push_end(3, 0, 1, 1'b0, 8 + 21 + 8 + 8);
    pulse_run(1'b0);
    wait_done("done_timeout");
    hang_idx = -1;

    // Ready on the last permitted WAIT cycle beats the timeout.
    late_idx = 1;
    push_starts(4); push_end(4, 0, 0, 1'b0, 8 + 23 + 8 + 8);
    pulse_run(1'b0);
    wait_done("done_late_ready");
    late_idx = -1;

    // Run while busy is ignored; abort+run in WAIT of index 1 returns to IDLE.
    hang_idx = 1;
    push_starts(2);
    pulse_run(1'b0);
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    wait_start_idx1("reach_idx1_start");
    @(negedge clk);
    abort = 1'b1; run = 1'b1;
    @(negedge clk);
    abort = 1'b0; run = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_start", dut_start, 0);
    chk("abort_correct", correct_cnt, 1);
    repeat (20) @(negedge clk);
    chk("abort_no_restart", busy, 0);
    chk("abort_counts_kept", {correct_cnt, wrong_cnt, timeout_cnt}, {3'd1, 3'd0, 3'd0});
    hang_idx = -1;

    // Reset in the FETCH of index 1 clears everything at once.
    push_starts(1);
    pulse_run(1'b0);
    n = 0;
    while (test_addr !== 2'd1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx1_fetch", test_addr, 1);
    rst = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("reset_no_resume", busy, 0);

    // Fresh sweep after reset, stop_on_err set but nothing fails.
    push_starts(4); push_end(4, 0, 0, 1'b0, 32);
    pulse_run(1'b1);
    wait_done("done_after_reset");

    repeat (3) @(negedge clk);
    chk("starts_drained", exp_vec_q.size(), 0);
    chk("mis_drained", exp_mis_q.size(), 0);
    chk("ends_drained", exp_end_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
